// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler
//   Per-scanline sprite evaluator and loader. On line_start it walks the sprite
//   attribute table, picks (in index order) up to SLOTS sprites whose 16-row
//   extent covers next_line, fetches each picked sprite's 32-bit pattern row
//   and writes it, with its attributes, into the per-slot registers used on
//   the following line.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   line_start          1-cycle pulse, next_line sampled with it
//   attr_addr/attr_rd   attribute table read; attr_data valid one cycle later
//   pat_req/pat_addr    pattern row request held until pat_valid (pat_data)
//   slot_we/slot_idx/slot_*   one-cycle load strobe with slot contents
//   slot_en             valid mask of loaded slots for the evaluated line
//   busy/done/overflow  evaluation status
module sprite_line_scheduler #(
  parameter int NUM_SPRITES = 32,
  parameter int SLOTS       = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           line_start,
  input  logic [8:0]                     next_line,
  output logic [$clog2(NUM_SPRITES)-1:0] attr_addr,
  output logic                           attr_rd,
  input  logic [31:0]                    attr_data,
  output logic                           pat_req,
  output logic [8:0]                     pat_addr,
  input  logic                           pat_valid,
  input  logic [31:0]                    pat_data,
  output logic                           slot_we,
  output logic [$clog2(SLOTS)-1:0]       slot_idx,
  output logic [8:0]                     slot_posx,
  output logic [31:0]                    slot_colors,
  output logic [3:0]                     slot_sclx,
  output logic                           slot_swpx,
  output logic [1:0]                     slot_pal,
  output logic [SLOTS-1:0]               slot_en,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);
  localparam int IW = $clog2(NUM_SPRITES);
  localparam int SW = $clog2(SLOTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);
  localparam logic [SW:0]   FULL     = (SW+1)'(SLOTS);
  localparam logic [SW:0]   ONE      = (SW+1)'(1);

  typedef enum logic [2:0] {IDLE, SCAN, EVAL, FETCH, LOAD, FINISH} state_t;

  state_t      state;
  logic [IW-1:0] idx;
  logic [SW:0] count;          // one extra bit so "all slots used" is representable
  logic [8:0]  line_q;
  logic        pending;        // line_start seen while a fetch was outstanding
  logic [8:0]  pending_line;

  // Attribute word fields (valid in EVAL)
  logic [8:0] a_posx, a_posy, row9;
  logic [3:0] a_sclx, row;
  logic       a_swpx, a_swpy, a_en, hit, last, restart;
  logic [4:0] a_pat;
  logic [1:0] a_pal;

  assign a_posx = attr_data[8:0];
  assign a_posy = attr_data[17:9];
  assign a_sclx = attr_data[21:18];
  assign a_swpx = attr_data[22];
  assign a_swpy = attr_data[23];
  assign a_en   = attr_data[24];
  assign a_pat  = attr_data[29:25];
  assign a_pal  = attr_data[31:30];

  // 9-bit subtraction wraps mod 512, so sprites straddling line 0 still hit.
  assign row9 = line_q - a_posy;
  assign hit  = a_en && (row9[8:4] == 5'd0);
  assign row  = a_swpy ? (4'd15 - row9[3:0]) : row9[3:0];
  assign last = (idx == LAST_IDX);

  assign attr_addr = idx;

  // A new line starts immediately in every state except FETCH, where the
  // outstanding request must be allowed to complete first.
  always_comb begin
    restart = 1'b0;
    case (state)
      FETCH:   restart = pat_valid && (pending || line_start);
      default: restart = line_start;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      count        <= '0;
      line_q       <= '0;
      pending      <= 1'b0;
      pending_line <= '0;
      attr_rd      <= 1'b0;
      pat_req      <= 1'b0;
      pat_addr     <= '0;
      slot_we      <= 1'b0;
      slot_idx     <= '0;
      slot_posx    <= '0;
      slot_colors  <= '0;
      slot_sclx    <= '0;
      slot_swpx    <= 1'b0;
      slot_pal     <= '0;
      slot_en      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      attr_rd <= 1'b0;
      slot_we <= 1'b0;
      done    <= 1'b0;
      if (restart) begin
        line_q   <= line_start ? next_line : pending_line;
        pending  <= 1'b0;
        idx      <= '0;
        count    <= '0;
        slot_en  <= '0;
        overflow <= 1'b0;
        busy     <= 1'b1;
        pat_req  <= 1'b0;  // any completed fetch data is simply dropped
        attr_rd  <= 1'b1;
        state    <= SCAN;
      end else begin
        case (state)
          IDLE: begin end
          SCAN: state <= EVAL;
          EVAL: begin
            if (hit) begin
              if (count == FULL) begin
                overflow <= 1'b1;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= FINISH;
              end else begin
                slot_posx <= a_posx;
                slot_sclx <= a_sclx;
                slot_swpx <= a_swpx;
                slot_pal  <= a_pal;
                pat_addr  <= {a_pat, row};
                pat_req   <= 1'b1;
                state     <= FETCH;
              end
            end else if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              idx     <= idx + IW'(1);
              attr_rd <= 1'b1;
              state   <= SCAN;
            end
          end
          FETCH: begin
            if (line_start) begin
              pending      <= 1'b1;
              pending_line <= next_line;
            end
            if (pat_valid) begin
              slot_colors               <= pat_data;
              pat_req                   <= 1'b0;
              slot_we                   <= 1'b1;
              slot_idx                  <= count[SW-1:0];
              slot_en[count[SW-1:0]]    <= 1'b1;
              state                     <= LOAD;
            end
          end
          LOAD: begin
            count <= count + ONE;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              idx     <= idx + IW'(1);
              attr_rd <= 1'b1;
              state   <= SCAN;
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler
//   Directed and randomized bench for sprite_line_scheduler. An attribute
//   table and a pattern memory are modelled at the negative edge; the expected
//   slot loads per line are derived from the table with plain arithmetic.
module tb_sprite_line_scheduler;
  localparam int NS = 32;
  localparam int SL = 8;

  typedef struct packed {
    logic [3:0]  idx;
    logic [8:0]  posx;
    logic [31:0] colors;
    logic [3:0]  sclx;
    logic        swpx;
    logic [1:0]  pal;
  } slot_rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic [8:0]  next_line = '0;
  logic [4:0]  attr_addr;
  logic        attr_rd;
  logic [31:0] attr_data = '0;
  logic        pat_req;
  logic [8:0]  pat_addr;
  logic        pat_valid = 1'b0;
  logic [31:0] pat_data = '0;
  logic        slot_we;
  logic [2:0]  slot_idx;
  logic [8:0]  slot_posx;
  logic [31:0] slot_colors;
  logic [3:0]  slot_sclx;
  logic        slot_swpx;
  logic [1:0]  slot_pal;
  logic [7:0]  slot_en;
  logic        busy, done, overflow;

  sprite_line_scheduler #(.NUM_SPRITES(NS), .SLOTS(SL)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .next_line(next_line),
    .attr_addr(attr_addr), .attr_rd(attr_rd), .attr_data(attr_data),
    .pat_req(pat_req), .pat_addr(pat_addr), .pat_valid(pat_valid), .pat_data(pat_data),
    .slot_we(slot_we), .slot_idx(slot_idx), .slot_posx(slot_posx), .slot_colors(slot_colors),
    .slot_sclx(slot_sclx), .slot_swpx(slot_swpx), .slot_pal(slot_pal), .slot_en(slot_en),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Environment state
  logic [31:0] tbl [NS];
  int          pat_delay = 0;
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / responder state (written only by the negedge process)
  logic        attr_pend = 1'b0;
  logic [4:0]  attr_pend_addr = '0;
  logic        req_prev = 1'b0;
  logic [8:0]  req_addr0 = '0;
  int          req_cycles = 0;
  int          last_req_cycles = 0;
  int          fetch_cnt = 0;
  int          unstable = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [8:0]  fetch_q [$];
  slot_rec_t   slot_q [$];

  function automatic logic [31:0] pat_fn(input logic [8:0] a);
    return {a[4:0], ~a, a, a} ^ 32'hC3A5_1E69;
  endfunction

  always @(negedge clk) begin
    slot_rec_t r;
    attr_data = attr_pend ? tbl[attr_pend_addr] : $urandom();
    attr_pend = attr_rd;
    attr_pend_addr = attr_addr;
    if (pat_req) begin
      if (!req_prev) begin
        fetch_cnt++;
        req_addr0 = pat_addr;
        req_cycles = 0;
        fetch_q.push_back(pat_addr);
      end else if (pat_addr !== req_addr0) begin
        unstable++;
      end
      req_cycles++;
      if (req_cycles - 1 == pat_delay) begin
        pat_valid = 1'b1;
        pat_data = pat_fn(pat_addr);
        last_req_cycles = req_cycles;
      end else begin
        pat_valid = 1'b0;
        pat_data = $urandom();
      end
    end else begin
      pat_valid = 1'b0;
      pat_data = $urandom();
    end
    req_prev = pat_req;
    if (slot_we) begin
      r.idx = {1'b0, slot_idx};
      r.posx = slot_posx;
      r.colors = slot_colors;
      r.sclx = slot_sclx;
      r.swpx = slot_swpx;
      r.pal = slot_pal;
      slot_q.push_back(r);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Checking
  int total = 0, passed = 0, failed = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk the table in index order, collecting hits.
  slot_rec_t exp_q [$];
  bit        exp_ovf;
  function automatic void build_model(input int line);
    slot_rec_t rec;
    int r, prow;
    exp_q.delete();
    exp_ovf = 0;
    for (int s = 0; s < NS; s++) begin
      r = (line - int'(tbl[s][17:9]) + 512) % 512;
      if (tbl[s][24] && r < 16) begin
        if (exp_q.size() == SL) begin
          exp_ovf = 1;
          break;
        end
        prow = tbl[s][23] ? 15 - r : r;
        rec.idx = 4'(exp_q.size());
        rec.posx = tbl[s][8:0];
        rec.colors = pat_fn({tbl[s][29:25], 4'(prow)});
        rec.sclx = tbl[s][21:18];
        rec.swpx = tbl[s][22];
        rec.pal = tbl[s][31:30];
        exp_q.push_back(rec);
      end
    end
  endfunction

  function automatic logic [31:0] mk_attr(input int posx, input int posy, input int pat,
                                          input bit en, input bit swpy);
    logic [31:0] a;
    a = '0;
    a[8:0] = 9'(posx);
    a[17:9] = 9'(posy);
    a[23] = swpy;
    a[24] = en;
    a[29:25] = 5'(pat);
    return a;
  endfunction

  task automatic clear_tbl();
    for (int s = 0; s < NS; s++) tbl[s] = '0;
  endtask

  int b_slot, b_fetch, b_done, b_unst, ls_cyc;

  task automatic start_line(input int line, input int dly);
    pat_delay = dly;
    b_slot = slot_q.size();
    b_fetch = fetch_cnt;
    b_done = done_cnt;
    b_unst = unstable;
    build_model(line);
    next_line = 9'(line);
    line_start = 1'b1;
    ls_cyc = cyc;
    @(posedge clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == b_done && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == b_done) check({tag, " done_timeout"}, 64'(done_cnt - b_done), 64'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch(input string tag);
    int n;
    n = 0;
    while (fetch_cnt == b_fetch && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (fetch_cnt == b_fetch) check({tag, " fetch_timeout"}, 64'(fetch_cnt - b_fetch), 64'd1);
  endtask

  task automatic check_line(input string tag, input int extra_fetch);
    check({tag, " loads"}, 64'(slot_q.size() - b_slot), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (b_slot + i < slot_q.size())
        check($sformatf("%s slot%0d", tag, i), 64'(slot_q[b_slot + i]), 64'(exp_q[i]));
    check({tag, " slot_en"}, 64'(slot_en), 64'((1 << exp_q.size()) - 1));
    check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
    check({tag, " done_count"}, 64'(done_cnt - b_done), 64'd1);
    check({tag, " fetch_count"}, 64'(fetch_cnt - b_fetch), 64'(exp_q.size() + extra_fetch));
    check({tag, " addr_stable"}, 64'(unstable - b_unst), 64'd0);
    check({tag, " busy_idle"}, 64'(busy), 64'd0);
    $display("line %s: loads=%0d overflow=%0d fetches=%0d", tag, slot_q.size() - b_slot,
             overflow, fetch_cnt - b_fetch);
  endtask

  initial begin
    clear_tbl();
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset slot_en", 64'(slot_en), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("reset pat_req", 64'(pat_req), 64'd0);
    check("reset attr_rd", 64'(attr_rd), 64'd0);
    check("reset slot_we", 64'(slot_we), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single sprite hit
    tbl[0] = mk_attr(100, 10, 3, 1, 0);
    start_line(12, 0);
    check("t1 busy", 64'(busy), 64'd1);
    wait_done("t1");
    check_line("t1", 0);
    if (fetch_q.size() > 0) check("t1 pat_addr", 64'(fetch_q[fetch_q.size() - 1]), 64'h032);

    // Row 16 is outside the sprite; empty pass takes 65 cycles
    start_line(26, 0);
    wait_done("t2a");
    check_line("t2a", 0);
    check("t2a done_cycle", 64'(done_cyc - ls_cyc), 64'd65);
    tbl[0] = mk_attr(100, 10, 3, 0, 0);
    start_line(12, 0);
    wait_done("t2b");
    check_line("t2b", 0);

    // Vertical swap and wrap-around
    tbl[0] = mk_attr(7, 10, 3, 1, 1);
    start_line(12, 0);
    wait_done("t3a");
    check_line("t3a", 0);
    if (fetch_q.size() > 0) check("t3a pat_addr", 64'(fetch_q[fetch_q.size() - 1]), 64'h03D);
    tbl[0] = mk_attr(300, 510, 7, 1, 0);
    start_line(2, 1);
    wait_done("t3b");
    check_line("t3b", 0);
    if (fetch_q.size() > 0) check("t3b pat_addr", 64'(fetch_q[fetch_q.size() - 1]), 64'h074);

    // Ten hits into eight slots
    clear_tbl();
    for (int s = 0; s < 10; s++) tbl[s] = mk_attr(10 * s, 100, s + 1, 1, 0);
    start_line(105, 0);
    wait_done("t4");
    check_line("t4", 0);
    check("t4 slot_en_full", 64'(slot_en), 64'hFF);
    check("t4 overflow_set", 64'(overflow), 64'd1);

    // Slow pattern memory
    clear_tbl();
    tbl[3] = mk_attr(50, 200, 9, 1, 0);
    start_line(207, 5);
    wait_done("t5");
    check_line("t5", 0);
    check("t5 req_cycles", 64'(last_req_cycles), 64'd6);

    // Restart while a fetch is outstanding
    clear_tbl();
    tbl[0] = mk_attr(11, 10, 1, 1, 0);
    tbl[5] = mk_attr(55, 35, 2, 1, 0);
    tbl[6] = mk_attr(66, 30, 4, 1, 1);
    start_line(12, 5);
    wait_fetch("t6");
    repeat (2) @(posedge clk);
    #1;
    build_model(40);
    next_line = 9'd40;
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    wait_done("t6");
    check_line("t6", 1);

    // Asynchronous reset while fetching
    clear_tbl();
    tbl[0] = mk_attr(1, 10, 1, 1, 0);
    start_line(12, 1000);
    wait_fetch("t7");
    #2;
    rst = 1'b1;
    #1;
    check("t7 async pat_req", 64'(pat_req), 64'd0);
    check("t7 async busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized tables
    for (int it = 0; it < 10; it++) begin
      int line, spread, r;
      logic [31:0] a;
      line = $urandom_range(0, 511);
      spread = 16 + it * 12;
      for (int s = 0; s < NS; s++) begin
        a = $urandom();
        r = $urandom_range(0, spread);
        a[17:9] = 9'((line - r + 512) % 512);
        a[24] = ($urandom_range(0, 2) != 0);
        tbl[s] = a;
      end
      start_line(line, $urandom_range(0, 3));
      wait_done($sformatf("rand%0d", it));
      check_line($sformatf("rand%0d", it), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
